// File: rtl/fa_tag_lookup.sv
// fa_tag_lookup: fully-associative tag compare and LRU command issue.
// Ports:
//   clk, reset (async, active-high)
//   req_valid_i/req_ready_o/req_op_i/req_tag_i : lookup/inval request
//   flush_i/flush_busy_o : sequenced whole-cache invalidate
//   ls_valid_o/ls_op_o/ls_way_o : command to LRU (LOAD/STORE/INVALIDATE)
//   lru_valid_i/lru_way_i : one-hot victim from LRU for STORE
//   resp_* : registered hit/miss/evict response
// Optional macro FA_TAG_MULTIHIT_CHK_EN adds sticky err_multihit_o.
module fa_tag_lookup #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 20,
    localparam int IW      = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [TAG_W-1:0]    req_tag_i,
    input  logic                flush_i,
    output logic                flush_busy_o,
    output logic                ls_valid_o,
    output logic [1:0]          ls_op_o,
    output logic [IW-1:0]       ls_way_o,
    input  logic                lru_valid_i,
    input  logic [NUM_WAYS-1:0] lru_way_i,
    output logic                resp_valid_o,
    output logic                resp_hit_o,
    output logic [IW-1:0]       resp_way_o,
    output logic                resp_evict_o,
    output logic [TAG_W-1:0]    resp_evict_tag_o
`ifdef FA_TAG_MULTIHIT_CHK_EN
    ,
    output logic                err_multihit_o
`endif
);

    localparam logic [1:0] OP_LOOKUP = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b11;
    localparam logic [1:0] LS_LOAD   = 2'b01;
    localparam logic [1:0] LS_STORE  = 2'b10;
    localparam logic [1:0] LS_INVAL  = 2'b11;
    localparam logic [IW-1:0] LAST_WAY = IW'(NUM_WAYS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_WAYS];
    logic [TAG_W-1:0]    tag_d [NUM_WAYS];
    logic                s1_vld_q, s1_vld_d;
    logic [1:0]          s1_op_q, s1_op_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic [IW-1:0]       cnt_q, cnt_d;

    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic [IW-1:0]       resp_way_q, resp_way_d;
    logic                resp_evict_q, resp_evict_d;
    logic [TAG_W-1:0]    resp_evict_tag_q, resp_evict_tag_d;

    logic [NUM_WAYS-1:0] match_vec;
    logic                hit;
    logic [IW-1:0]       hit_idx;
    logic [IW-1:0]       lru_idx;
    logic                accept;
    logic                walk;

    // Tag compare; lowest matching way wins on multi-hit.
    always_comb begin
        hit_idx = '0;
        lru_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            match_vec[i] = valid_q[i] && (tag_q[i] == s1_tag_q);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (match_vec[i]) hit_idx = IW'(i);
            if (lru_way_i[i]) lru_idx = IW'(i);
        end
        hit = |match_vec;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_i) state_d = FLUSH;
            FLUSH:   if (!s1_vld_q && cnt_q == LAST_WAY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        flush_busy_o = (state_q == FLUSH);
        // Walk only once S1 has drained so ls_* never carries two commands.
        walk         = (state_q == FLUSH) && !s1_vld_q;
    end

    assign accept = req_valid_i && req_ready_o;

    // S1 compare, ls command, array update, response
    always_comb begin
        valid_d          = valid_q;
        tag_d            = tag_q;
        s1_vld_d         = accept;
        s1_op_d          = s1_op_q;
        s1_tag_d         = s1_tag_q;
        cnt_d            = cnt_q;
        ls_valid_o       = 1'b0;
        ls_op_o          = 2'b00;
        ls_way_o         = '0;
        resp_valid_d     = s1_vld_q;
        resp_hit_d       = 1'b0;
        resp_way_d       = '0;
        resp_evict_d     = 1'b0;
        resp_evict_tag_d = '0;

        if (accept) begin
            s1_op_d  = req_op_i;
            s1_tag_d = req_tag_i;
        end

        if (s1_vld_q) begin
            case (s1_op_q)
                OP_LOOKUP: begin
                    ls_valid_o = 1'b1;
                    if (hit) begin
                        ls_op_o    = LS_LOAD;
                        ls_way_o   = hit_idx;
                        resp_hit_d = 1'b1;
                        resp_way_d = hit_idx;
                    end else begin
                        ls_op_o = LS_STORE;
                        if (lru_valid_i) begin
                            tag_d[lru_idx]   = s1_tag_q;
                            valid_d[lru_idx] = 1'b1;
                            resp_way_d       = lru_idx;
                            resp_evict_d     = valid_q[lru_idx];
                            resp_evict_tag_d = tag_q[lru_idx];
                        end
                    end
                end
                OP_INVAL: begin
                    if (hit) begin
                        ls_valid_o       = 1'b1;
                        ls_op_o          = LS_INVAL;
                        ls_way_o         = hit_idx;
                        valid_d[hit_idx] = 1'b0;
                        resp_hit_d       = 1'b1;
                        resp_way_d       = hit_idx;
                    end
                end
                default: ;
            endcase
        end else if (walk) begin
            ls_valid_o     = 1'b1;
            ls_op_o        = LS_INVAL;
            ls_way_o       = cnt_q;
            valid_d[cnt_q] = 1'b0;
            // Wraps to zero after the last way, ready for the next flush.
            cnt_d          = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            s1_vld_q         <= 1'b0;
            s1_op_q          <= 2'b00;
            s1_tag_q         <= '0;
            cnt_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            resp_way_q       <= '0;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            s1_vld_q         <= s1_vld_d;
            s1_op_q          <= s1_op_d;
            s1_tag_q         <= s1_tag_d;
            cnt_q            <= cnt_d;
            resp_valid_q     <= resp_valid_d;
            resp_hit_q       <= resp_hit_d;
            resp_way_q       <= resp_way_d;
            resp_evict_q     <= resp_evict_d;
            resp_evict_tag_q <= resp_evict_tag_d;
        end
    end

    // Tag storage is qualified by valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            tag_q[i] <= tag_d[i];
        end
    end

    assign resp_valid_o     = resp_valid_q;
    assign resp_hit_o       = resp_hit_q;
    assign resp_way_o       = resp_way_q;
    assign resp_evict_o     = resp_evict_q;
    assign resp_evict_tag_o = resp_evict_tag_q;

`ifdef FA_TAG_MULTIHIT_CHK_EN
    logic err_multihit_q, err_multihit_d;
    logic multi;

    // More than one bit set: clearing the lowest set bit leaves a nonzero.
    always_comb begin
        multi = (match_vec & (match_vec - 1'b1)) != '0;
        err_multihit_d = err_multihit_q;
        if (s1_vld_q && (s1_op_q == OP_LOOKUP || s1_op_q == OP_INVAL)
            && multi) begin
            err_multihit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_multihit_q <= 1'b0;
        else       err_multihit_q <= err_multihit_d;
    end

    assign err_multihit_o = err_multihit_q;
`endif

endmodule

// File: tb/tb_fa_tag_lookup.sv
// tb_fa_tag_lookup: directed + random check of fa_tag_lookup
// against a cycle-level behavioural model of the tag store.
module tb_fa_tag_lookup;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [1:0] req_op_i = 2'b00;
    logic [7:0] req_tag_i = 8'h00;
    logic       flush_i = 1'b0;
    logic       flush_busy_o;
    logic       ls_valid_o;
    logic [1:0] ls_op_o;
    logic [1:0] ls_way_o;
    logic       lru_valid_i = 1'b0;
    logic [3:0] lru_way_i = 4'b0001;
    logic       resp_valid_o;
    logic       resp_hit_o;
    logic [1:0] resp_way_o;
    logic       resp_evict_o;
    logic [7:0] resp_evict_tag_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fa_tag_lookup #(.NUM_WAYS(4), .TAG_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_tag_i        (req_tag_i),
        .flush_i          (flush_i),
        .flush_busy_o     (flush_busy_o),
        .ls_valid_o       (ls_valid_o),
        .ls_op_o          (ls_op_o),
        .ls_way_o         (ls_way_o),
        .lru_valid_i      (lru_valid_i),
        .lru_way_i        (lru_way_i),
        .resp_valid_o     (resp_valid_o),
        .resp_hit_o       (resp_hit_o),
        .resp_way_o       (resp_way_o),
        .resp_evict_o     (resp_evict_o),
        .resp_evict_tag_o (resp_evict_tag_o)
    );

    // Reference model state
    bit         m_val [4];
    logic [7:0] m_tag [4];
    bit         s1_v;
    logic [1:0] s1_op;
    logic [7:0] s1_tag;
    bit         fl_on;
    int         fl_cnt;
    bit         r_v, r_hit, r_ev;
    int         r_way;
    logic [7:0] r_etag;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_val[i] = 0;
        s1_v  = 0;
        fl_on = 0;
        fl_cnt = 0;
        r_v   = 0;
    endtask

    // Called just after a rising edge with this cycle's inputs driven.
    task automatic cycle();
        bit         e_rdy, e_lv, acc;
        int         e_lop, e_lway, h, w;
        bit         n_hit, n_ev;
        int         n_way;
        logic [7:0] n_etag;
        e_rdy = !fl_on;
        e_lv = 0; e_lop = 0; e_lway = 0;
        n_hit = 0; n_way = 0; n_ev = 0; n_etag = 8'h00;
        if (s1_v) begin
            h = -1;
            for (int i = 3; i >= 0; i--)
                if (m_val[i] && m_tag[i] == s1_tag) h = i;
            if (s1_op == 2'b01) begin
                e_lv = 1;
                if (h >= 0) begin
                    e_lop = 1; e_lway = h; n_hit = 1; n_way = h;
                end else begin
                    e_lop = 2;
                    if (lru_valid_i) begin
                        w = 0;
                        for (int i = 3; i >= 0; i--)
                            if (lru_way_i[i]) w = i;
                        n_way = w;
                        n_ev = m_val[w];
                        n_etag = m_tag[w];
                        m_tag[w] = s1_tag;
                        m_val[w] = 1;
                    end
                end
            end else if (s1_op == 2'b11 && h >= 0) begin
                e_lv = 1; e_lop = 3; e_lway = h;
                m_val[h] = 0; n_hit = 1; n_way = h;
            end
        end else if (fl_on) begin
            e_lv = 1; e_lop = 3; e_lway = fl_cnt;
            m_val[fl_cnt] = 0;
            fl_cnt++;
            if (fl_cnt == 4) fl_on = 0;
        end
        if (e_rdy && flush_i) begin
            fl_on = 1;
            fl_cnt = 0;
        end
        acc = req_valid_i && e_rdy;

        @(negedge clk);
        chk("ready", req_ready_o, e_rdy);
        chk("busy", flush_busy_o, !e_rdy);
        chk("ls_valid", ls_valid_o, e_lv);
        if (e_lv) begin
            chk("ls_op", ls_op_o, e_lop);
            chk("ls_way", ls_way_o, e_lway);
        end
        chk("resp_valid", resp_valid_o, r_v);
        if (r_v) begin
            chk("resp_hit", resp_hit_o, r_hit);
            chk("resp_way", resp_way_o, r_way);
            chk("resp_evict", resp_evict_o, r_ev);
            if (r_ev) chk("resp_etag", resp_evict_tag_o, r_etag);
        end

        @(posedge clk);
        #1;
        r_v = s1_v; r_hit = n_hit; r_way = n_way;
        r_ev = n_ev; r_etag = n_etag;
        s1_v = acc; s1_op = req_op_i; s1_tag = req_tag_i;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_busy", flush_busy_o, 1'b0);
        chk("rst_ls_valid", ls_valid_o, 1'b0);
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic req(input logic [1:0] op, input logic [7:0] tag);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_tag_i = tag;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fill(input logic [7:0] base);
        lru_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lru_way_i = 4'b0001 << i;
            req(2'b01, base + 8'(i));
            idle(1);
        end
        idle(1);
    endtask

    initial begin
        do_reset();

        // hit after miss on same tag
        lru_valid_i = 1'b1;
        lru_way_i = 4'b0001;
        req(2'b01, 8'h11); idle(2);
        req(2'b01, 8'h11); idle(2);

        // eviction of a valid way
        fill(8'hA0);
        lru_way_i = 4'b0010;
        req(2'b01, 8'hB0); idle(2);
        lru_way_i = 4'b1000;
        req(2'b01, 8'hA1); idle(2);

        // invalidate hit / miss
        req(2'b11, 8'hA2); idle(2);
        lru_valid_i = 1'b0;
        req(2'b01, 8'hA2); idle(2);
        req(2'b11, 8'h55); idle(2);
        req(2'b00, 8'hB0); req(2'b10, 8'hB0); idle(2);

        // back-to-back same tag
        do_reset();
        lru_valid_i = 1'b1;
        lru_way_i = 4'b0100;
        req(2'b01, 8'h33); req(2'b01, 8'h33); idle(2);

        // flush with concurrent accepted request
        fill(8'hC0);
        flush_i = 1'b1;
        req(2'b01, 8'hC2);
        flush_i = 1'b1;
        idle(7);
        lru_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) req(2'b01, 8'hC0 + 8'(i));
        idle(2);

        // reset in the middle of a flush walk
        fill(8'hD0);
        flush_i = 1'b1;
        cycle();
        while (fl_on && fl_cnt < 1) cycle();
        do_reset();
        idle(2);
        lru_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) req(2'b01, 8'hD0 + 8'(i));
        idle(2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_op_i = ($urandom_range(0, 4) == 0) ? 2'($urandom)
                     : (($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01);
            req_tag_i = 8'h10 + 8'($urandom_range(0, 7));
            flush_i = ($urandom_range(0, 40) == 0);
            lru_valid_i = ($urandom_range(0, 3) != 0);
            lru_way_i = 4'b0001 << $urandom_range(0, 3);
            cycle();
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
